// File: rtl/tone_pkg.sv
// Shared constants and state encoding for the tone meter.
package tone_pkg;

    localparam int unsigned TONE_W       = 15;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned SILENT_TICKS = 32768;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEASURE
    } state_t;

endpackage

// File: rtl/tone_meter_tick_gen.sv
// Tick divider: 1-clk pulse every TICK_DIV clocks while enabled, cleared when disabled.
module tick_gen #(
    parameter int unsigned TICK_DIV = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(TICK_DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/tone_meter.sv
// Measures the half-period of an external square wave in ticks and reports it as code N-1,
// with lock tracking across consecutive matching measurements and silence detection.
module tone_meter
    import tone_pkg::*;
#(
    parameter int unsigned TICK_DIV = 12,
    parameter int unsigned MIN_HALF = 4,
    parameter int unsigned TOL      = 2,
    parameter int unsigned STABLE_N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sig_in,
    output logic [TONE_W-1:0] tone_code,
    output logic              tone_valid,
    output logic              locked,
    output logic              silent
);

    localparam int unsigned MW = $clog2(STABLE_N + 1);

    logic              tick;
    logic              sync1, sync2, sync3;
    logic              edge_c;
    state_t            state, state_d;
    logic [CNT_W-1:0]  half_cnt, half_cnt_d;
    logic [CNT_W-1:0]  n_prev, n_prev_d;
    logic [MW-1:0]     match, match_d;
    logic [TONE_W-1:0] tone_code_d;
    logic              tone_valid_d, locked_d, silent_d;
    logic [CNT_W-1:0]  n_c, diff_c;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    // Two-flop synchroniser plus a history flop for any-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_c = sync2 ^ sync3;

    // Tick-inclusive count; saturates so an edge at the silence boundary reports 32768
    assign n_c    = (tick && (half_cnt < CNT_W'(SILENT_TICKS))) ? half_cnt + CNT_W'(1) : half_cnt;
    assign diff_c = (n_c >= n_prev) ? n_c - n_prev : n_prev - n_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            half_cnt   <= '0;
            n_prev     <= '0;
            match      <= '0;
            tone_code  <= '0;
            tone_valid <= 1'b0;
            locked     <= 1'b0;
            silent     <= 1'b0;
        end else begin
            state      <= state_d;
            half_cnt   <= half_cnt_d;
            n_prev     <= n_prev_d;
            match      <= match_d;
            tone_code  <= tone_code_d;
            tone_valid <= tone_valid_d;
            locked     <= locked_d;
            silent     <= silent_d;
        end
    end

    always_comb begin
        state_d      = state;
        half_cnt_d   = half_cnt;
        n_prev_d     = n_prev;
        match_d      = match;
        tone_code_d  = tone_code;
        tone_valid_d = 1'b0;
        locked_d     = locked;
        silent_d     = silent;

        if (!enable) begin
            // Any partial measurement is dropped; reported values hold
            state_d    = IDLE;
            half_cnt_d = '0;
            match_d    = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    half_cnt_d = '0;
                    match_d    = '0;
                    state_d    = WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    half_cnt_d = '0;
                    if (edge_c) begin
                        state_d  = MEASURE;
                        silent_d = 1'b0;
                    end
                end
                MEASURE: begin
                    if (edge_c) begin
                        half_cnt_d = '0;
                        if (n_c < CNT_W'(MIN_HALF)) begin
                            match_d  = '0;
                            locked_d = 1'b0;
                        end else begin
                            tone_code_d  = TONE_W'(n_c - CNT_W'(1));
                            tone_valid_d = 1'b1;
                            if (diff_c <= CNT_W'(TOL)) begin
                                match_d = (match == MW'(STABLE_N)) ? match : match + MW'(1);
                            end else begin
                                match_d = MW'(1);
                            end
                            locked_d = (match_d == MW'(STABLE_N));
                            n_prev_d = n_c;
                        end
                    end else if (half_cnt == CNT_W'(SILENT_TICKS)) begin
                        state_d    = WAIT_EDGE;
                        half_cnt_d = '0;
                        silent_d   = 1'b1;
                        locked_d   = 1'b0;
                    end else begin
                        half_cnt_d = n_c;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
